bram_playback: RTL and testbench

BRAM_PLAYBACK -- requirements
Module: bram_playback

---
 rtl/bram_playback.sv | 143 ++++++++++++++
 tb/tb_bram_playback.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_playback.sv
// bram_playback: fetches blockram words over Wishbone and plays them out as a serial bitstream
module bram_playback #(
    parameter int unsigned CLK_DIV  = 75,
    parameter int unsigned LAST_ADR = 2047,
    parameter bit          LOOP     = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        reset_n,
    input  logic        enable_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        dout_o,
    output logic        dout_clk_o,
    output logic        underrun_o,
    output logic        done_o,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT_ACK = 2'b10, FULL = 2'b11} state_t;
    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d, shift_q, shift_d;
    logic        hold_valid_q, hold_valid_d, shift_valid_q, shift_valid_d;
    logic [4:0]  bit_ctr_q, bit_ctr_d;
    logic [15:0] div_ctr_q, div_ctr_d;
    logic [10:0] adr_ctr_q, adr_ctr_d;
    logic        fin_q, fin_d, played_q, played_d, dout_q, dout_d;
    logic        underrun_q, underrun_d, done_q, done_d;
    logic        busy, ack, tick, last_bit, take, at_last;

    assign busy       = state_q == REQ || state_q == WAIT_ACK;
    assign ack        = busy && wb_ack_i;
    assign tick       = enable_i && div_ctr_q == 16'(CLK_DIV - 1);
    assign last_bit   = bit_ctr_q == 5'd31;
    assign take       = tick && hold_valid_q && (!shift_valid_q || last_bit);
    assign at_last    = adr_ctr_q == 11'(LAST_ADR);
    assign wb_cyc_o   = busy;
    assign wb_stb_o   = busy;
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = busy ? 4'hF : 4'h0;
    assign wb_adr_o   = {19'd0, adr_ctr_q, 2'b00};
    assign dout_o     = dout_q;
    assign dout_clk_o = div_ctr_q >= 16'(CLK_DIV / 2);
    assign underrun_o = underrun_q;
    assign done_o     = done_q;
    assign state_o    = state_q;

    // Next state: fetch FSM, bit divider, hold/shift double buffer; disabling waits out any open bus cycle
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        shift_d       = shift_q;
        shift_valid_d = shift_valid_q;
        bit_ctr_d     = bit_ctr_q;
        div_ctr_d     = div_ctr_q;
        adr_ctr_d     = adr_ctr_q;
        fin_d         = fin_q;
        played_d      = played_q;
        dout_d        = dout_q;
        underrun_d    = underrun_q;
        done_d        = done_q;
        if (!enable_i) begin
            if (!busy || wb_ack_i) begin
                state_d       = IDLE;
                hold_valid_d  = 1'b0;
                shift_valid_d = 1'b0;
                bit_ctr_d     = '0;
                div_ctr_d     = '0;
                adr_ctr_d     = '0;
                fin_d         = 1'b0;
                played_d      = 1'b0;
                dout_d        = 1'b0;
                underrun_d    = 1'b0;
                done_d        = 1'b0;
            end
        end else begin
            div_ctr_d = tick ? 16'd0 : div_ctr_q + 16'd1;
            if (tick && shift_valid_q) begin
                dout_d    = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_ctr_d = bit_ctr_q + 5'd1;
                played_d  = 1'b1;
                if (last_bit) begin
                    shift_d       = hold_valid_q ? hold_q : shift_q >> 1;
                    shift_valid_d = hold_valid_q;
                    done_d        = done_q || (LOOP == 1'b0 && fin_q && !hold_valid_q);
                end
            end else if (tick) begin
                dout_d        = 1'b0;
                shift_d       = hold_valid_q ? hold_q : shift_q;
                shift_valid_d = hold_valid_q;
                underrun_d    = underrun_q || (!hold_valid_q && played_q && !(LOOP == 1'b0 && fin_q));
            end
            hold_valid_d = take ? 1'b0 : hold_valid_q;
            if (ack) begin
                hold_d       = wb_dat_i;
                hold_valid_d = 1'b1;
                adr_ctr_d    = at_last ? 11'd0 : adr_ctr_q + 11'd1;
                fin_d        = fin_q || (LOOP == 1'b0 && at_last);
            end
            state_d = state_q == IDLE ? ((!hold_valid_q && !fin_q) ? REQ : IDLE) :
                      state_q == FULL ? (take ? IDLE : FULL) :
                      ack ? FULL : WAIT_ACK;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            shift_q       <= '0;
            shift_valid_q <= 1'b0;
            bit_ctr_q     <= '0;
            div_ctr_q     <= '0;
            adr_ctr_q     <= '0;
            fin_q         <= 1'b0;
            played_q      <= 1'b0;
            dout_q        <= 1'b0;
            underrun_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            shift_q       <= shift_d;
            shift_valid_q <= shift_valid_d;
            bit_ctr_q     <= bit_ctr_d;
            div_ctr_q     <= div_ctr_d;
            adr_ctr_q     <= adr_ctr_d;
            fin_q         <= fin_d;
            played_q      <= played_d;
            dout_q        <= dout_d;
            underrun_q    <= underrun_d;
            done_q        <= done_d;
        end
    end
endmodule

// File: tb/tb_bram_playback.sv
// tb_bram_playback: directed vectors for one-shot and looping playback, underrun, disable and reset
module tb_bram_playback;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en_a = 1'b0, cyc_a, stb_a, we_a, ack_a = 1'b0, dout_a, dclk_a, und_a, done_a;
    logic [3:0]  sel_a;
    logic [31:0] adr_a, dat_a = '0;
    logic [1:0]  st_a;
    logic        en_b = 1'b0, cyc_b, stb_b, we_b, ack_b = 1'b0, dout_b, dclk_b, und_b, done_b;
    logic [3:0]  sel_b;
    logic [31:0] adr_b, dat_b = '0;
    logic [1:0]  st_b;

    bram_playback #(.CLK_DIV(4), .LAST_ADR(1), .LOOP(1'b0)) dut_a (
        .wb_clk_i(clk), .reset_n(rst_n), .enable_i(en_a), .wb_cyc_o(cyc_a), .wb_stb_o(stb_a),
        .wb_we_o(we_a), .wb_sel_o(sel_a), .wb_adr_o(adr_a), .wb_dat_i(dat_a), .wb_ack_i(ack_a),
        .dout_o(dout_a), .dout_clk_o(dclk_a), .underrun_o(und_a), .done_o(done_a), .state_o(st_a));

    bram_playback #(.CLK_DIV(75), .LAST_ADR(2), .LOOP(1'b1)) dut_b (
        .wb_clk_i(clk), .reset_n(rst_n), .enable_i(en_b), .wb_cyc_o(cyc_b), .wb_stb_o(stb_b),
        .wb_we_o(we_b), .wb_sel_o(sel_b), .wb_adr_o(adr_b), .wb_dat_i(dat_b), .wb_ack_i(ack_b),
        .dout_o(dout_b), .dout_clk_o(dclk_b), .underrun_o(und_b), .done_o(done_b), .state_o(st_b));

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          d1;
        logic        exp_und;
        logic        exp_done;
    } vec_t;

    vec_t        tv [4];
    logic [31:0] mem_a [4], mem_b [4];
    int          dly_a [4];
    logic [31:0] log_a [$], log_b [$];
    logic [31:0] ea [5];
    int          n_cmp = 0, n_err = 0, cyc_n = 0, cnt_a = 0, cnt_b = 0, ack_cyc_a = 0;
    int          k, bad, ph, ticks, bad_clk, bad_dout, bad_done;
    logic        synced, pd, pdo, fall;
    logic [63:0] got;

    always @(posedge clk) cyc_n++;

    // Blockram slaves: ack after a per-word delay, logging each acked address
    always @(negedge clk) begin
        if (cyc_a && stb_a && !ack_a) begin
            cnt_a++;
            if (cnt_a > dly_a[adr_a[3:2]]) begin
                ack_a = 1'b1;
                dat_a = mem_a[adr_a[3:2]];
                ack_cyc_a = cyc_n;
                log_a.push_back(adr_a);
            end
        end else begin
            ack_a = 1'b0;
            cnt_a = 0;
        end
        if (cyc_b && stb_b && !ack_b) begin
            ack_b = 1'b1;
            dat_b = mem_b[adr_b[3:2]];
            log_b.push_back(adr_b);
        end else begin
            ack_b = 1'b0;
            cnt_b = 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_tick_a();
        logic p;
        int n = 0;
        do begin
            p = dclk_a;
            @(negedge clk);
            n++;
        end while (!(p && !dclk_a) && n < 1000);
        if (n >= 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL tick_a: no bit tick within 1000 cycles");
        end
    endtask

    initial begin
        tv[0] = '{32'hABCDEF01, 32'h12345678, 0, 1'b0, 1'b1};
        tv[1] = '{32'hFFFFFFFF, 32'h00000000, 1, 1'b0, 1'b1};
        tv[2] = '{32'h5A5A5A5A, 32'hA5A5A5A5, 3, 1'b0, 1'b1};
        tv[3] = '{32'h80000001, 32'h7FFFFFFE, 40, 1'b0, 1'b1};
        ea = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4};
        for (int i = 0; i < 4; i++) begin
            dly_a[i] = 0;
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_bus_a", {cyc_a, stb_a, we_a, sel_a, adr_a}, 0);
        chk("rst_out_a", {dout_a, dclk_a, und_a, done_a, st_a}, 0);
        chk("rst_bus_b", {cyc_b, stb_b, we_b, sel_b, adr_b}, 0);
        chk("rst_out_b", {dout_b, dclk_b, und_b, done_b, st_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            mem_a[0] = tv[v].w0;
            mem_a[1] = tv[v].w1;
            dly_a[1] = tv[v].d1;
            en_a = 1'b1;
            wait_tick_a();
            chk($sformatf("load_bit%0d", v), dout_a, 0);
            for (int i = 0; i < 64; i++) begin
                wait_tick_a();
                got[i] = dout_a;
                if (i == 62) chk($sformatf("done_early%0d", v), done_a, 0);
            end
            chk($sformatf("stream%0d", v), got, {tv[v].w1, tv[v].w0});
            chk($sformatf("done%0d", v), done_a, tv[v].exp_done);
            chk($sformatf("underrun%0d", v), und_a, tv[v].exp_und);
            wait_tick_a();
            wait_tick_a();
            chk($sformatf("tail%0d", v), {und_a, dout_a, done_a}, {2'b00, tv[v].exp_done});
            en_a = 1'b0;
            @(negedge clk);
            chk($sformatf("disable_clear%0d", v), {done_a, und_a, dout_a, st_a, cyc_a}, 0);
            log_a.delete();
        end

        mem_a[0] = 32'hABCDEF01;
        mem_a[1] = 32'h12345678;
        dly_a[1] = 200;
        en_a = 1'b1;
        wait_tick_a();
        for (int i = 0; i < 32; i++) begin
            wait_tick_a();
            got[i] = dout_a;
        end
        chk("u_word0", got[31:0], 32'hABCDEF01);
        chk("u_not_yet", und_a, 0);
        wait_tick_a();
        chk("u_set", {und_a, dout_a, cyc_a}, 3'b101);
        bad = 0;
        for (k = 0; k < 200; k++) begin
            wait_tick_a();
            if (dout_a !== 1'b0 || und_a !== 1'b1) bad++;
            if (log_a.size() >= 2 && cyc_n > ack_cyc_a + 1) break;
        end
        chk("u_gap_zero", bad, 0);
        chk("u_loaded", k < 200, 1);
        for (int i = 0; i < 32; i++) begin
            wait_tick_a();
            got[i] = dout_a;
        end
        chk("u_word1", got[31:0], 32'h12345678);
        chk("u_sticky_done", {und_a, done_a}, 2'b11);
        en_a = 1'b0;
        @(negedge clk);
        log_a.delete();
        dly_a[1] = 0;

        dly_a[0] = 20;
        en_a = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (st_a == 2'b10) break;
        end
        chk("drain_reached", k < 200, 1);
        en_a = 1'b0;
        @(negedge clk);
        chk("drain_hold", {cyc_a, stb_a, sel_a, st_a, adr_a}, {2'b11, 4'hF, 2'b10, 32'h0});
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!cyc_a) break;
        end
        chk("drain_acked", log_a.size(), 1);
        chk("drain_clear", {cyc_a, stb_a, we_a, sel_a, adr_a, dout_a, dclk_a, und_a, done_a, st_a}, 0);
        log_a.delete();
        dly_a[0] = 0;
        en_a = 1'b1;
        for (k = 0; k < 100 && log_a.size() < 2; k++) @(negedge clk);
        chk("reen_fetches", log_a.size(), 2);
        chk("reen_first_adr", log_a[0], 32'h0);
        en_a = 1'b0;
        @(negedge clk);
        log_a.delete();

        dly_a[0] = 100;
        en_a = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (st_a == 2'b10) break;
        end
        chk("arst_reached", k < 200, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("arst_bus", {cyc_a, stb_a, sel_a, st_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en_a = 1'b0;
        dly_a[0] = 0;
        @(negedge clk);
        log_a.delete();
        en_a = 1'b1;
        for (k = 0; k < 100 && log_a.size() < 1; k++) @(negedge clk);
        chk("arst_resume", {log_a.size() == 1, log_a[0]}, {1'b1, 32'h0});
        en_a = 1'b0;

        mem_b[0] = 32'hF0E1D2C3;
        mem_b[1] = 32'h0F1E2D3C;
        mem_b[2] = 32'h55AA33CC;
        en_b = 1'b1;
        synced = 1'b0;
        ph = 0;
        ticks = 0;
        bad_clk = 0;
        bad_dout = 0;
        bad_done = 0;
        for (k = 0; k < 12000 && log_b.size() < 5; k++) begin
            pd = dclk_b;
            pdo = dout_b;
            @(negedge clk);
            fall = pd && !dclk_b;
            if (fall) begin
                ph = 0;
                synced = 1'b1;
                ticks++;
            end else ph++;
            if (synced && dclk_b !== (ph >= 37)) bad_clk++;
            if (dout_b !== pdo && !fall) bad_dout++;
            if (done_b !== 1'b0) bad_done++;
        end
        chk("b_fetches", log_b.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("b_adr%0d", i), log_b[i], ea[i]);
        chk("b_clk_shape", bad_clk, 0);
        chk("b_dout_at_ticks", bad_dout, 0);
        chk("b_done_low", bad_done, 0);
        chk("b_no_underrun", und_b, 0);
        chk("b_ticks", ticks >= 90, 1);
        en_b = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
